uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmitter for the multi-clock-domain system. It accepts a parallel byte with a one-cycle valid strobe and serialises it onto TX_OUT as an asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity, then one stop bit. It is the transmit end of the UART and drives the line decoded by the UART RX FSM. It runs in the TX clock domain, and its Busy flag is fed back to the upstream FIFO-read / system-control logic.

## Interface
- DATA_WIDTH, 8, width of the parallel data word.
- CLKS_PER_BIT, 1, clk cycles per serial bit; must be >= 1. The value 1 means clk is the baud clock.
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- P_DATA  input  DATA_WIDTH  byte to send; sampled only on acceptance.
- Data_Valid  input  1  request strobe; takes effect only in IDLE.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- TX_OUT  output  1  serial line, registered, idle high.
- Busy  output  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset state is IDLE. On the clock edge where rst is high: TX_OUT=1, Busy=0, and all counters and holding registers are cleared. This applies regardless of current state; an aborted frame is never resumed.
- IDLE:
  - TX_OUT=1, Busy=0.
  - Data_Valid=1 is accepted. The block latches P_DATA into the shift register and latches PAR_EN and PAR_TYP.
  - The block computes the parity bit at acceptance: ^P_DATA for even, ~^P_DATA for odd.
  - Next state is START.
- START: TX_OUT=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - TX_OUT = shift register bit 0; the register shifts right at each bit boundary.
  - The bit counter runs 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = latched parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: TX_OUT=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Busy=1 in every non-IDLE state.
- Data_Valid while Busy=1 is ignored; it is not queued.
- Changes on P_DATA, PAR_EN or PAR_TYP during a frame do not affect that frame.
- Prescale counter:
  - Width max(1, $clog2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
- Bit counter:
  - Width max(1, $clog2(DATA_WIDTH)).
  - Cleared on entry to DATA; no wrap beyond DATA_WIDTH-1.
- Illegal state encodings return to IDLE on the next edge with TX_OUT=1 and Busy=0.

## Timing
- Data_Valid is sampled high at edge N in IDLE. At edge N+1, TX_OUT=0 and Busy=1.
- Frame length F = (DATA_WIDTH + 2 + PAR_EN) * CLKS_PER_BIT cycles. This is 10 cycles, or 11 with parity, at the defaults.
- Timing of the last stop-bit cycle:
  - The last stop-bit cycle is cycles N+F .. N+F.
  - At edge N+F+1: Busy=0 and TX_OUT=1 (IDLE).
- Minimum accept-to-accept spacing is F+1 cycles, so there is one idle-high cycle between back-to-back frames at CLKS_PER_BIT=1.
- The earliest next accept is Data_Valid high at edge N+F+1.
- TX_OUT and Busy are glitch-free registered outputs. Neither has a combinational path from any input.
- If rst and Data_Valid are high on the same edge, rst wins: nothing is accepted.

## Test plan
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then inputs quiet.
  - Required: TX_OUT=1 and Busy=0 continuously.
- CLKS_PER_BIT=1, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 strobed for 1 cycle.
  - Required TX_OUT from N+1: 0,1,0,1,0,0,1,0,1,0,1 (parity=0).
  - Required Busy high for exactly 11 cycles, then TX_OUT=1.
- PAR_TYP=1, P_DATA=0xFF.
  - Required: data bits 1×8, parity 1, stop 1.
- PAR_EN=0, P_DATA=0x00.
  - Required: 0 for 9 cycles, stop 1, Busy high for 10 cycles.
- Busy rejection:
  - Stimulus: start 0x3C, then strobe Data_Valid with 0xC3 at N+4 and change PAR_EN mid-frame.
  - Required: frame 0x3C transmitted unaltered and no second frame. Then 0xC3 strobed at N+F+1 starts at N+F+2.
- CLKS_PER_BIT=16 with P_DATA=0x81, and reset mid-DATA:
  - Stimulus: P_DATA=0x81. Separately, rst=1 during bit 3 of a frame.
  - Required: each bit is held exactly 16 cycles, F=176 with parity.
  - Required for the mid-DATA reset: TX_OUT=1 and Busy=0 on the next edge, and a new frame is accepted afterwards normally.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: accepts a parallel word on a one-cycle strobe and serialises
// it as start bit, LSB-first data, optional even/odd parity and one stop bit.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int PRESC_W = ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W   = ($clog2(DATA_WIDTH) > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PRESC_W-1:0]     presc_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   tx_d;
  logic                   busy_d;
  logic                   bit_end;
  logic                   accept;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d,
                                     input logic                  odd);
    parity_of = odd ? ~^d : ^d;
  endfunction

  assign bit_end = (presc_cnt == PRESC_LAST);
  assign accept  = (state == IDLE) && Data_Valid;

  // Next state and the line/busy values that get registered on the next edge.
  always_comb begin
    state_nxt = state;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) state_nxt = START;
      end
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_d   = shift_q[0];
        busy_d = 1'b1;
        if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_d   = par_bit_q;
        busy_d = 1'b1;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        if (bit_end) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  // busy_d is high exactly in the legal non-IDLE states, so it also gates the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (!busy_d || bit_end) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state != DATA) begin
      bit_cnt <= '0;
    end else if (bit_end && (bit_cnt != BIT_LAST)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Frame contents are frozen at acceptance; parity is resolved then as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      shift_q   <= P_DATA;
      par_en_q  <= PAR_EN;
      par_bit_q <= parity_of(P_DATA, PAR_TYP);
    end else if ((state == DATA) && bit_end) begin
      shift_q   <= shift_q >> 1;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance at the baud clock, one at 16 clocks per bit.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst16, dv1, dv16;
  logic [7:0] p_data;
  logic       par_en, par_typ;
  logic       tx1, busy1, tx16, busy16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst1), .P_DATA(p_data), .Data_Valid(dv1),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx1), .Busy(busy1)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) u16 (
    .clk(clk), .rst(rst16), .P_DATA(p_data), .Data_Valid(dv16),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx16), .Busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx16 : tx1;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy16 : busy1;
  endfunction

  task automatic set_dv(input bit sel, input logic v);
    if (sel) dv16 = v;
    else     dv1  = v;
  endtask

  task automatic idle_check(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_of(sel)), 32'd1);
      check($sformatf("%s_busy%0d", tag, i), 32'(busy_of(sel)), 32'd0);
    end
  endtask

  // exp holds the frame in line order: exp[0] start, exp[8:1] data, then parity/stop.
  // Ends 1 ns after edge N+F, so a following call strobes at edge N+F+1.
  task automatic run_frame(input bit sel, input logic [7:0] d, input logic pe,
                           input logic pt, input logic [10:0] exp, input int nbits,
                           input bit inject, input string tag);
    int cpb;
    cpb     = sel ? 16 : 1;
    p_data  = d;
    par_en  = pe;
    par_typ = pt;
    set_dv(sel, 1'b1);
    tick();
    set_dv(sel, 1'b0);
    check({tag, "_acc_tx"}, 32'(tx_of(sel)), 32'd1);
    check({tag, "_acc_busy"}, 32'(busy_of(sel)), 32'd0);
    for (int k = 1; k <= nbits * cpb; k++) begin
      tick();
      check($sformatf("%s_tx%0d", tag, k), 32'(tx_of(sel)), 32'(exp[(k-1)/cpb]));
      check($sformatf("%s_busy%0d", tag, k), 32'(busy_of(sel)), 32'd1);
      if (inject && k == 2) begin
        par_en  = ~pe;
        par_typ = ~pt;
      end
      if (inject && k == 3) begin
        p_data = 8'hC3;
        set_dv(sel, 1'b1);
      end
      if (inject && k == 4) set_dv(sel, 1'b0);
    end
  endtask

  initial begin
    logic [10:0] exp55;
    rst1 = 1'b1; rst16 = 1'b1; dv1 = 1'b0; dv16 = 1'b0;
    p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;

    tick();
    check("rst1_c1_tx", 32'(tx1), 32'd1);
    check("rst1_c1_busy", 32'(busy1), 32'd0);
    check("rst16_c1_tx", 32'(tx16), 32'd1);
    tick();
    check("rst1_c2_tx", 32'(tx1), 32'd1);
    check("rst16_c2_busy", 32'(busy16), 32'd0);
    rst1 = 1'b0; rst16 = 1'b0;
    idle_check(0, 4, "idle1");
    idle_check(1, 2, "idle16");

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    run_frame(0, 8'hA5, 1'b1, 1'b0, 11'b1_0_10100101_0, 11, 0, "a5");
    idle_check(0, 2, "a5_end");

    // 0xFF odd parity -> parity bit 1
    run_frame(0, 8'hFF, 1'b1, 1'b1, 11'b1_1_11111111_0, 11, 0, "ff");
    idle_check(0, 2, "ff_end");

    // 0x00 without parity: nine zeros then stop
    run_frame(0, 8'h00, 1'b0, 1'b0, 11'b0_1_00000000_0, 10, 0, "z0");
    idle_check(0, 2, "z0_end");

    // 0x3C even parity with a strobe at N+4 and config changes mid-frame,
    // then 0xC3 strobed at N+F+1 back to back
    run_frame(0, 8'h3C, 1'b1, 1'b0, 11'b1_0_00111100_0, 11, 1, "rej");
    run_frame(0, 8'hC3, 1'b0, 1'b0, 11'b0_1_11000011_0, 10, 0, "b2b");
    idle_check(0, 4, "b2b_end");

    // rst and Data_Valid together: nothing accepted
    rst1 = 1'b1; dv1 = 1'b1; p_data = 8'h00; par_en = 1'b0;
    tick();
    rst1 = 1'b0; dv1 = 1'b0;
    check("rstdv_tx", 32'(tx1), 32'd1);
    check("rstdv_busy", 32'(busy1), 32'd0);
    idle_check(0, 3, "rstdv_idle");

    // 16 clocks per bit, 0x81 even parity (parity 0), F = 176
    run_frame(1, 8'h81, 1'b1, 1'b0, 11'b1_0_10000001_0, 11, 0, "c16");
    idle_check(1, 2, "c16_end");

    // 0x55 (bit 3 = 0), reset sampled during data bit 3
    exp55   = 11'b1_0_01010101_0;
    p_data  = 8'h55; par_en = 1'b1; par_typ = 1'b0;
    dv16    = 1'b1;
    tick();
    dv16    = 1'b0;
    for (int k = 1; k <= 69; k++) begin
      tick();
      check($sformatf("mid_tx%0d", k), 32'(tx16), 32'(exp55[(k-1)/16]));
    end
    check("mid_bit3_tx", 32'(tx16), 32'd0);
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    check("mid_rst_tx", 32'(tx16), 32'd1);
    check("mid_rst_busy", 32'(busy16), 32'd0);
    idle_check(1, 3, "mid_idle");

    // new frame after the abort: 0x3C without parity
    run_frame(1, 8'h3C, 1'b0, 1'b0, 11'b0_1_00111100_0, 10, 0, "post");
    idle_check(1, 2, "post_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
